// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch (IF) and load/store (LS), with LS lane alignment and load extension.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration in place of LS priority plus IF starvation guard.
module mem_arbiter #(
  parameter int SIZE       = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_req,
  input  logic [31:0]     i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [31:0]     o_if_rdata,
  input  logic            i_ls_req,
  input  logic [2:0]      i_ls_ctrl,
  input  logic [31:0]     i_ls_addr,
  input  logic [31:0]     i_ls_wdata,
  output logic            o_ls_gnt,
  output logic            o_ls_rvalid,
  output logic [31:0]     o_ls_rdata,
  output logic            o_ls_err,
  output logic            o_mem_en,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_be,
  output logic [SIZE-1:0] o_mem_addr,
  output logic [31:0]     o_mem_wdata,
  input  logic [31:0]     i_mem_rdata
);

  localparam logic [2:0] CTRL_LB  = 3'b000;
  localparam logic [2:0] CTRL_LH  = 3'b001;
  localparam logic [2:0] CTRL_LW  = 3'b010;
  localparam logic [2:0] CTRL_LBU = 3'b011;
  localparam logic [2:0] CTRL_LHU = 3'b100;
  localparam logic [2:0] CTRL_SB  = 3'b101;
  localparam logic [2:0] CTRL_SH  = 3'b110;
  localparam logic [2:0] CTRL_SW  = 3'b111;

  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_if_prio;
  logic        w_ls_mis;
  logic        w_ls_store;
  logic [1:0]  w_ls_off;

  logic        r_if_rv;
  logic        r_ls_rv;
  logic        r_ls_err;
  logic [2:0]  r_ls_ctrl;
  logic [1:0]  r_ls_off;

  logic [31:0] w_shift;
  logic [31:0] w_ls_ext;
  logic        w_unused;

  assign w_ls_off   = i_ls_addr[1:0];
  assign w_ls_store = (i_ls_ctrl == CTRL_SB) || (i_ls_ctrl == CTRL_SH) || (i_ls_ctrl == CTRL_SW);

  always_comb begin
    w_ls_mis = 1'b0;
    case (i_ls_ctrl)
      CTRL_LH, CTRL_LHU, CTRL_SH: w_ls_mis = i_ls_addr[0];
      CTRL_LW, CTRL_SW:           w_ls_mis = (i_ls_addr[1:0] != 2'b00);
      default:                    w_ls_mis = 1'b0;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  // r_last_ls: 0 = IF granted most recently, 1 = LS
  logic r_last_ls;

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_last_ls <= 1'b0;
    else if (w_if_gnt) r_last_ls <= 1'b0;
    else if (w_ls_gnt) r_last_ls <= 1'b1;
  end

  assign w_if_prio = r_last_ls;
`else
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CW-1:0] r_starve;

  always_ff @(posedge i_clk) begin
    if (i_rst)                     r_starve <= '0;
    else if (i_if_req && !w_if_gnt) r_starve <= r_starve + 1'b1;
    else                           r_starve <= '0;
  end

  assign w_if_prio = (r_starve == CW'(STARVE_MAX));
`endif

  // Grants are suppressed in reset so every output reads zero there
  assign w_ls_gnt = !i_rst && i_ls_req && !(i_if_req && w_if_prio);
  assign w_if_gnt = !i_rst && i_if_req && !w_ls_gnt;
  assign o_ls_gnt = w_ls_gnt;
  assign o_if_gnt = w_if_gnt;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = 32'h0;
    if (w_if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_be   = 4'b1111;
      o_mem_addr = i_if_addr[SIZE+1:2];
    end else if (w_ls_gnt && !w_ls_mis) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_ls_addr[SIZE+1:2];
      o_mem_we   = w_ls_store;
      case (i_ls_ctrl)
        CTRL_SB: begin
          o_mem_be    = 4'b0001 << w_ls_off;
          o_mem_wdata = {4{i_ls_wdata[7:0]}};
        end
        CTRL_SH: begin
          o_mem_be    = 4'b0011 << w_ls_off;
          o_mem_wdata = {2{i_ls_wdata[15:0]}};
        end
        CTRL_SW: begin
          o_mem_be    = 4'b1111;
          o_mem_wdata = i_ls_wdata;
        end
        default: o_mem_be = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_rv   <= 1'b0;
      r_ls_rv   <= 1'b0;
      r_ls_err  <= 1'b0;
      r_ls_ctrl <= 3'b000;
      r_ls_off  <= 2'b00;
    end else begin
      r_if_rv  <= w_if_gnt;
      r_ls_rv  <= w_ls_gnt;
      r_ls_err <= w_ls_gnt && w_ls_mis;
      if (w_ls_gnt) begin
        r_ls_ctrl <= i_ls_ctrl;
        r_ls_off  <= w_ls_off;
      end
    end
  end

  assign w_shift = i_mem_rdata >> {r_ls_off, 3'b000};

  always_comb begin
    w_ls_ext = 32'h0;
    case (r_ls_ctrl)
      CTRL_LB:  w_ls_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      CTRL_LH:  w_ls_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      CTRL_LW:  w_ls_ext = w_shift;
      CTRL_LBU: w_ls_ext = {24'h0, w_shift[7:0]};
      CTRL_LHU: w_ls_ext = {16'h0, w_shift[15:0]};
      default:  w_ls_ext = 32'h0;
    endcase
  end

  // A response registered just before reset must not leak out during reset
  assign o_if_rvalid = r_if_rv && !i_rst;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'h0;
  assign o_ls_rvalid = r_ls_rv && !i_rst;
  assign o_ls_err    = o_ls_rvalid && r_ls_err;
  assign o_ls_rdata  = (o_ls_rvalid && !r_ls_err) ? w_ls_ext : 32'h0;

  assign w_unused = ^{i_if_addr[31:SIZE+2], i_if_addr[1:0], i_ls_addr[31:SIZE+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: alignment, extension, misalignment, arbitration pattern and reset abort.
// Arbitration expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic [2:0]  ls_ctrl;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.SIZE(12), .STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_ctrl(ls_ctrl), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata), .o_ls_err(ls_err),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ls_issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd);
    ls_req   = 1'b1;
    ls_ctrl  = c;
    ls_addr  = a;
    ls_wdata = wd;
    #1;
  endtask

  // advance to the response cycle with requests dropped
  task automatic step();
    @(negedge clk);
    ls_req = 1'b0;
    if_req = 1'b0;
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] exp);
    @(negedge clk);
    ls_issue(c, a, 32'h0);
    chk({tag, "_gnt"}, ls_gnt, 1);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_be"}, mem_be, 4'hF);
    step();
    chk({tag, "_rv"}, ls_rvalid, 1);
    chk({tag, "_rd"}, ls_rdata, exp);
  endtask

  logic exp_if;

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1;
    ls_ctrl = 3'b010; ls_addr = 32'h0; ls_wdata = 32'h0; mem_rdata = 32'h80AA_BBCC;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ifgnt", if_gnt, 0);
    chk("rst_lsgnt", ls_gnt, 0);
    chk("rst_memen", mem_en, 0);
    chk("rst_ifrv", if_rvalid, 0);
    chk("rst_lsrv", ls_rvalid, 0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    #1;
    chk("idle_memen", mem_en, 0);
    chk("idle_be", mem_be, 0);
    chk("idle_lsrd", ls_rdata, 0);
    chk("idle_ifrd", if_rdata, 0);

    // loads from word 0x80AA_BBCC
    @(negedge clk);
    ls_issue(3'b000, 32'h003, 32'h0);
    chk("lb_ifgnt", if_gnt, 0);
    chk("lb_memen", mem_en, 1);
    chk("lb_addr", mem_addr, 0);
    step();
    chk("lb_err", ls_err, 0);
    load_chk("lb", 3'b000, 32'h003, 32'hFFFF_FF80);
    load_chk("lbu", 3'b011, 32'h003, 32'h0000_0080);
    load_chk("lb0", 3'b000, 32'h000, 32'hFFFF_FFCC);
    load_chk("lh", 3'b001, 32'h002, 32'hFFFF_80AA);
    load_chk("lhu", 3'b100, 32'h002, 32'h0000_80AA);
    load_chk("lhu0", 3'b100, 32'h000, 32'h0000_BBCC);
    load_chk("lw", 3'b010, 32'h004, 32'h80AA_BBCC);

    // stores
    @(negedge clk);
    ls_issue(3'b110, 32'h006, 32'h1234_ABCD);
    chk("sh_we", mem_we, 1);
    chk("sh_be", mem_be, 4'hC);
    chk("sh_wd", mem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", mem_addr, 1);
    step();
    chk("sh_rv", ls_rvalid, 1);
    chk("sh_err", ls_err, 0);
    chk("sh_rd", ls_rdata, 0);

    @(negedge clk);
    ls_issue(3'b101, 32'h001, 32'h5566_77EF);
    chk("sb_be", mem_be, 4'h2);
    chk("sb_wd", mem_wdata, 32'hEFEF_EFEF);
    step();
    chk("sb_rv", ls_rvalid, 1);

    @(negedge clk);
    ls_issue(3'b111, 32'h008, 32'hDEAD_BEEF);
    chk("sw_be", mem_be, 4'hF);
    chk("sw_wd", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", mem_addr, 2);
    step();
    chk("sw_rd", ls_rdata, 0);

    // misaligned accesses
    @(negedge clk);
    ls_issue(3'b010, 32'h002, 32'h0);
    chk("mis_lw_gnt", ls_gnt, 1);
    chk("mis_lw_en", mem_en, 0);
    chk("mis_lw_we", mem_we, 0);
    step();
    chk("mis_lw_rv", ls_rvalid, 1);
    chk("mis_lw_err", ls_err, 1);
    chk("mis_lw_rd", ls_rdata, 0);
    chk("mis_lw_en2", mem_en, 0);

    @(negedge clk);
    ls_issue(3'b110, 32'h005, 32'hFFFF_FFFF);
    chk("mis_sh_en", mem_en, 0);
    chk("mis_sh_we", mem_we, 0);
    step();
    chk("mis_sh_err", ls_err, 1);

    // IF read
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10; #1;
    chk("if_gnt", if_gnt, 1);
    chk("if_addr", mem_addr, 4);
    chk("if_be", mem_be, 4'hF);
    chk("if_we", mem_we, 0);
    step();
    chk("if_rv", if_rvalid, 1);
    chk("if_rd", if_rdata, 32'h80AA_BBCC);
    chk("if_lsrv", ls_rvalid, 0);

    // arbitration with both requests held
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_ctrl = 3'b010; ls_addr = 32'h0;
    #1;
    for (int i = 0; i < 12; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_if = (i % 2 == 1);
`else
      exp_if = (i % 5 == 4);
`endif
      chk($sformatf("arb_if%0d", i), if_gnt, exp_if);
      chk($sformatf("arb_ls%0d", i), ls_gnt, !exp_if);
      @(negedge clk); #1;
    end
    if_req = 1'b0; ls_req = 1'b0;

    // reset right after an IF grant drops its response
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h20; #1;
    chk("ra_gnt", if_gnt, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("ra_rv", if_rvalid, 0);
    chk("ra_rd", if_rdata, 0);
    chk("ra_gnt2", if_gnt, 0);
    chk("ra_en", mem_en, 0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("pr_gnt", if_gnt, 1);
    chk("pr_addr", mem_addr, 8);
    step();
    chk("pr_rv", if_rvalid, 1);
    chk("pr_rd", if_rdata, 32'h80AA_BBCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
